// File: rtl/alu_result_mux.sv
// ALU result selector: picks one packed input channel per accepted beat and
// queues the result with zero/range flags in a two-entry skid buffer.
module alu_result_mux #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_IN*WIDTH-1:0] i_in_data,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic [WIDTH-1:0]        o_out_data,
  output logic [SEL_W-1:0]        o_out_sel,
  output logic                    o_out_zero,
  output logic                    o_out_sel_err,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_err_sticky
);

  localparam int unsigned PAY_W = WIDTH + SEL_W + 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PAY_W-1:0]   r_main;
  logic [PAY_W-1:0]   r_skid;
  logic               r_err_sticky;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_sel_err;
  logic [PAY_W-1:0]   w_pay;
  logic               w_accept;
  logic               w_consume;

  // Channel selection; out-of-range selectors yield zero data
  always_comb begin
    w_sel_data = '0;
    w_sel_err  = (32'(i_sel) >= NUM_IN);
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_sel_data = i_in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_pay     = {w_sel_data, i_sel, (w_sel_data == '0), w_sel_err};
  assign w_accept  = i_in_valid && o_in_ready;
  assign w_consume = o_out_valid && i_out_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_accept && !w_consume)      w_state_nxt = ST_FULL;
        else if (!w_accept && w_consume) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_consume) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake outputs decoded from state; ready is held low during reset
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_EMPTY: o_in_ready = !i_rst;
      ST_ONE: begin
        o_in_ready  = !i_rst;
        o_out_valid = 1'b1;
      end
      ST_FULL:  o_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Main/skid payload registers and sticky error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_main <= w_pay;
        ST_ONE: begin
          if (w_accept && w_consume) r_main <= w_pay;
          else if (w_accept)         r_skid <= w_pay;
        end
        ST_FULL:  if (w_consume) r_main <= r_skid;
        default: ;
      endcase
      if (w_accept && w_sel_err) r_err_sticky <= 1'b1;
    end
  end

  assign {o_out_data, o_out_sel, o_out_zero, o_out_sel_err} = r_main;
  assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_alu_result_mux.sv
// Self-checking bench for alu_result_mux: scoreboard of expected beats plus
// per-scenario directed checks.
module tb_alu_result_mux;

  localparam int unsigned WIDTH  = 24;
  localparam int unsigned NUM_IN = 4;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned PAY_W  = WIDTH + SEL_W + 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_zero;
  logic                    out_sel_err;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_sticky;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [PAY_W-1:0] sb[$];
  logic             stall = 1'b0;
  logic [PAY_W-1:0] held;

  always #5 clk = ~clk;

  alu_result_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_data    (in_data),
    .i_sel        (sel),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_out_data   (out_data),
    .o_out_sel    (out_sel),
    .o_out_zero   (out_zero),
    .o_out_sel_err(out_sel_err),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_err_sticky (err_sticky)
  );

  function automatic logic [PAY_W-1:0] model(input logic [NUM_IN*WIDTH-1:0] d,
                                             input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] v;
    logic             e;
    e = (s > 3'd3);
    v = e ? 24'h0 : 24'(d >> (32'(s) * 24));
    return {v, s, (v == 24'h0), e};
  endfunction

  // One cycle: observe handshakes in the settled low phase, then advance.
  task automatic tick();
    logic [PAY_W-1:0] exp_pay;
    logic [PAY_W-1:0] act;
    #1;
    act = {out_data, out_sel, out_zero, out_sel_err};
    if (rst) begin
      sb.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (act !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", act, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got beat %h want none", act);
        end else begin
          exp_pay = sb.pop_front();
          pops++;
          if (act !== exp_pay) begin
            errors++;
            $display("FAIL sb_beat: got %h want %h", act, exp_pay);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, sel));
      stall = out_valid && !out_ready;
      held  = act;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sel = 3'd1;
    in_data = {24'h1, 24'h2, 24'h3, 24'h4};
    tick();
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if ({out_data, out_sel, out_zero, out_sel_err, out_valid, err_sticky} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h/%b/%b/%b/%b want all 0",
               out_data, out_sel, out_zero, out_sel_err, out_valid, err_sticky);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset: got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    in_data = {24'h000003, 24'h123456, 24'h00FFFF, 24'hF0F0F0};
    sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = '1; sel = 3'd7;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h123456 || out_sel !== 3'd2 ||
        out_zero !== 1'b0 || out_sel_err !== 1'b0) begin
      errors++;
      $display("FAIL single: got v=%b d=%h s=%0d z=%b e=%b want 1 123456 2 0 0",
               out_valid, out_data, out_sel, out_zero, out_sel_err);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int start_pops;
    start_pops = pops;
    in_data = {24'hAAAA03, 24'h00BB01, 24'h0C0C0C, 24'h0000D0};
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 3'd0; tick();
    sel = 3'd1; tick();
    sel = 3'd3;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    tick(); tick();
    checks++;
    if (out_data !== 24'h0000D0 || out_sel !== 3'd0) begin
      errors++; $display("FAIL bp_hold: got %h sel %0d want 0000d0 sel 0", out_data, out_sel);
    end
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (pops - start_pops != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d beats (%0d queued) want 3 (0)", pops - start_pops, sb.size());
    end
  endtask

  task automatic test_out_of_range();
    in_data = {24'h111111, 24'h222222, 24'h333333, 24'h444444};
    sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    sel = 3'd3;
    #1;
    checks++;
    if (out_data !== 24'h0 || out_zero !== 1'b1 || out_sel_err !== 1'b1 ||
        err_sticky !== 1'b1 || out_sel !== 3'd5) begin
      errors++;
      $display("FAIL oor: got d=%h s=%0d z=%b e=%b st=%b want 0 5 1 1 1",
               out_data, out_sel, out_zero, out_sel_err, err_sticky);
    end
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (err_sticky !== 1'b1 || out_sel_err !== 1'b0) begin
      errors++; $display("FAIL sticky_hold: got st=%b e=%b want 1 0", err_sticky, out_sel_err);
    end
  endtask

  task automatic test_zero_flag();
    in_data = {24'h000009, 24'h000008, 24'h000007, 24'h000000};
    sel = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_zero !== 1'b1 || out_sel_err !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL zero_flag: got z=%b e=%b v=%b want 1 0 1", out_zero, out_sel_err, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_full();
    in_data = {24'h0D0D0D, 24'h0C0C0C, 24'h0B0B0B, 24'h0A0A0A};
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 3'd2; tick();
    sel = 3'd3; tick();
    rst = 1'b1; sel = 3'd0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_full_ready: got %b want 0", in_ready);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL rst_full_after: got v=%b r=%b st=%b want 0 1 0", out_valid, in_ready, err_sticky);
    end
    sel = 3'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h0B0B0B || out_sel !== 3'd1) begin
      errors++; $display("FAIL rst_full_first: got v=%b d=%h s=%0d want 1 0b0b0b 1", out_valid, out_data, out_sel);
    end
    tick();
  endtask

  task automatic test_streaming();
    int start_pops;
    int stalls;
    start_pops = pops;
    stalls = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = {$urandom(), $urandom(), $urandom()};
      if (i % 9 == 0) in_data[23:0] = 24'h0;
      sel = 3'($urandom_range(0, 3));
      #1;
      if (in_ready !== 1'b1) stalls++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL stream_ready: got %0d stalled cycles want 0", stalls);
    end
    checks++;
    if (pops - start_pops != 100 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d beats (%0d queued) want 100 (0)", pops - start_pops, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_out_of_range();
    test_zero_flag();
    test_reset_full();
    test_streaming();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
